countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Consumes the encoder's digit/strobe outputs (D, load, pgt_1Hz) and keeps the cook time as four BCD digits, MM:SS.
//  In IDLE, each keypad strobe shifts the entered digit in from the right. In RUN, each 1 Hz edge decrements MM:SS with BCD borrow.
//  At 00:00 it signals done to the oven controller. Digit outputs drive the 7-segment display decoders directly.
// PARAMETERS
//  SEC_TENS_WRAP    5  value loaded into sec_tens on a seconds borrow (00 -> 59)
//  DONE_HOLD_TICKS  3  number of pgt_1Hz rising edges for which done is held before returning to IDLE (1..15)
// PORTS
//  clk        in   1  system clock; the only clock in the block
//  clear_n    in   1  reset, asynchronous, active-low
//  D          in   4  digit from keypad encoder, BCD 0-9; values 10-15 are invalid
//  load       in   1  high while a decoded key is present
//  pgt_1Hz    in   1  strobe from encoder mux: debounced key in IDLE, 1 Hz tick otherwise; treated as data
//  start      in   1  level, start/resume request
//  stop       in   1  level, pause/cancel request
//  min_tens   out  4  BCD digit
//  min_ones   out  4  BCD digit
//  sec_tens   out  4  BCD digit
//  sec_ones   out  4  BCD digit
//  running    out  1  high in RUN
//  done       out  1  high in DONE
//  zero       out  1  all four digits == 0 (combinational from digit registers)
// BEHAVIOUR
//  - Reset (clear_n=0, async):
//    - state = IDLE; all digits = 0; tick-edge register = 0; hold counter = 0.
//    - running = 0, done = 0, zero = 1.
//  - Edge detect: pgt_q <= pgt_1Hz each clk; tick = pgt_1Hz & ~pgt_q.
//    - All tick actions take effect at the clk edge that first samples pgt_1Hz high.
//    - Outputs are visible 1 clk after that edge. A held-high pgt_1Hz produces exactly one tick.
//  - IDLE:
//    - tick & load & D<=9: {mt,mo,st,so} <= {mo,st,so,D}. The oldest digit falls off; there is no entry limit.
//    - tick & load & D>9: ignored.
//    - stop: all digits cleared to 0.
//    - start & !zero -> RUN. start & zero: ignored.
//  - RUN:
//    - tick: decrement MM:SS.
//      - so: 0 -> 9 with borrow, else so-1.
//      - st (on borrow): 0 -> SEC_TENS_WRAP with borrow to minutes, else st-1.
//      - mo/mt: plain BCD decrement with borrow.
//      - Entered seconds >59 (e.g. 0090) are not normalised; they count down 0089, 0088, ...
//    - If the decrement result is 0000 -> DONE. This takes priority over a simultaneous stop.
//    - stop (with no terminal tick) -> PAUSE; any decrement in the same cycle still applies.
//    - load/D are ignored.
//  - PAUSE:
//    - Digits frozen; ticks ignored.
//    - start -> RUN. stop -> IDLE with digits cleared.
//    - start & stop together: stop wins.
//  - DONE:
//    - Digits = 0000; hold counter cleared on entry.
//    - Each tick increments the counter; on reaching DONE_HOLD_TICKS -> IDLE.
//    - stop -> IDLE immediately. start: ignored.
//  - Global rule: start & stop in the same cycle in any state = stop only.
//  - Reset mid-RUN: immediate return to the reset values; no done pulse is generated.
// TESTING
//  1 Reset values: hold clear_n=0 -> digits 0, zero=1, running=0, done=0. Release, idle 10 clk -> unchanged.
//  2 Entry: key ticks D=1,3,0 (load=1) -> digits 0,1,3,0. Then D=12 tick -> unchanged. Then stop -> 0000.
//  3 Countdown: load 0102, start, 3 ticks -> 0101, 0100, 0059; running=1 throughout.
//  4 Terminal: load 0002, start, 2 ticks -> 0000, done=1, running=0. 3 more ticks -> IDLE, done=0.
//  5 Pause/resume: RUN at 0010, stop -> PAUSE. 5 ticks -> still 0010. start, 1 tick -> 0009. stop, stop -> IDLE, 0000.
//  6 Edge cases:
//    - pgt_1Hz held high 20 clk in RUN -> exactly one decrement.
//    - start & stop together in IDLE -> stays IDLE, digits cleared.
//    - clear_n low mid-RUN at 0030 -> 0000 asynchronously, running=0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Keypad/tick inputs and BCD display outputs of the countdown timer.
interface countdown_timer_if;
  logic [3:0] D;
  logic       load;
  logic       pgt_1Hz;
  logic       start;
  logic       stop;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  logic       zero;

  modport master (
    output D, load, pgt_1Hz, start, stop,
    input  min_tens, min_ones, sec_tens, sec_ones, running, done, zero
  );

  modport slave (
    input  D, load, pgt_1Hz, start, stop,
    output min_tens, min_ones, sec_tens, sec_ones, running, done, zero
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD cook timer: keypad entry in IDLE, 1 Hz countdown in RUN, done hold afterwards.
// Outputs registered one clk after the sampling edge; no backpressure, every tick is consumed.
module countdown_timer #(
  parameter int SEC_TENS_WRAP   = 5,
  parameter int DONE_HOLD_TICKS = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_q;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] hold_q;
  logic       pgt_q;
  logic       running_q;
  logic       done_q;

  logic       tick;
  logic       zero;
  logic [3:0] mt_dec, mo_dec, st_dec, so_dec;
  logic       dec_zero;

  assign tick = bus.pgt_1Hz & ~pgt_q;
  assign zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);

  // Borrow ripples right to left; seconds tens wraps to SEC_TENS_WRAP, minutes to 9.
  always_comb begin
    so_dec = (so_q == 4'd0) ? 4'd9 : so_q - 4'd1;
    st_dec = st_q;
    mo_dec = mo_q;
    mt_dec = mt_q;
    if (so_q == 4'd0) begin
      st_dec = (st_q == 4'd0) ? 4'(SEC_TENS_WRAP) : st_q - 4'd1;
      if (st_q == 4'd0) begin
        mo_dec = (mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1;
        if (mo_q == 4'd0) begin
          mt_dec = (mt_q == 4'd0) ? 4'd9 : mt_q - 4'd1;
        end
      end
    end
    dec_zero = (mt_dec == 4'd0) && (mo_dec == 4'd0) && (st_dec == 4'd0) && (so_dec == 4'd0);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      mt_q      <= 4'd0;
      mo_q      <= 4'd0;
      st_q      <= 4'd0;
      so_q      <= 4'd0;
      hold_q    <= 4'd0;
      pgt_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pgt_q <= bus.pgt_1Hz;
      case (state_q)
        IDLE: begin
          if (bus.stop) begin
            {mt_q, mo_q, st_q, so_q} <= 16'h0000;
          end else begin
            if (tick && bus.load && (bus.D <= 4'd9)) begin
              {mt_q, mo_q, st_q, so_q} <= {mo_q, st_q, so_q, bus.D};
            end
            if (bus.start && !zero) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            {mt_q, mo_q, st_q, so_q} <= {mt_dec, mo_dec, st_dec, so_dec};
          end
          // Reaching 0000 outranks a coincident stop.
          if (tick && dec_zero) begin
            state_q   <= DONE;
            hold_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bus.stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state_q                  <= IDLE;
            {mt_q, mo_q, st_q, so_q} <= 16'h0000;
          end else if (bus.start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hold_q  <= 4'd0;
          end else if (tick) begin
            if (hold_q + 4'd1 == 4'(DONE_HOLD_TICKS)) begin
              state_q <= IDLE;
              done_q  <= 1'b0;
              hold_q  <= 4'd0;
            end else begin
              hold_q <= hold_q + 4'd1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min_tens = mt_q;
  assign bus.min_ones = mo_q;
  assign bus.sec_tens = st_q;
  assign bus.sec_ones = so_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.zero     = zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected display state queued per step, popped and compared.
module tb_countdown_timer;

  logic clk;
  logic clear_n;

  countdown_timer_if bus ();

  countdown_timer #(
    .SEC_TENS_WRAP  (5),
    .DONE_HOLD_TICKS(3)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic expect_st(input string tag, input logic [15:0] dig,
                           input logic run, input logic dn);
    exp_t e;
    e.tag = tag;
    e.v   = {dig, run, dn, (dig == 16'h0000)};
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t        e;
    logic [18:0] obs;
    e   = sb.pop_front();
    obs = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
           bus.running, bus.done, bus.zero};
    n_cmp++;
    assert (obs === e.v) else begin
      n_mis++;
      $error("FAIL %s: observed digits=%h run=%b done=%b zero=%b expected digits=%h run=%b done=%b zero=%b",
             e.tag, obs[18:3], obs[2], obs[1], obs[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  task automatic check(input string tag, input logic [15:0] dig,
                       input logic run, input logic dn);
    expect_st(tag, dig, run, dn);
    @(negedge clk);
    compare_pop();
  endtask

  task automatic tick();
    bus.pgt_1Hz = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.pgt_1Hz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.load = 1'b1;
    bus.D    = d;
    tick();
    bus.load = 1'b0;
    bus.D    = 4'd0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
  endtask

  initial begin
    clear_n     = 1'b0;
    bus.D       = 4'd0;
    bus.load    = 1'b0;
    bus.pgt_1Hz = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset", 16'h0000, 1'b0, 1'b0);
    clear_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle10", 16'h0000, 1'b0, 1'b0);

    key(4'd1); key(4'd3); key(4'd0);
    check("entry", 16'h0130, 1'b0, 1'b0);
    key(4'd12);
    check("bad_digit", 16'h0130, 1'b0, 1'b0);
    pulse_stop();
    check("stop_clear", 16'h0000, 1'b0, 1'b0);
    pulse_start();
    check("start_zero", 16'h0000, 1'b0, 1'b0);
    key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5);
    check("shift_out", 16'h8765, 1'b0, 1'b0);
    pulse_stop();

    key(4'd1); key(4'd0); key(4'd2);
    check("load0102", 16'h0102, 1'b0, 1'b0);
    pulse_start();
    check("run_start", 16'h0102, 1'b1, 1'b0);
    tick();
    check("dec_0101", 16'h0101, 1'b1, 1'b0);
    tick();
    check("dec_0100", 16'h0100, 1'b1, 1'b0);
    tick();
    check("borrow_0059", 16'h0059, 1'b1, 1'b0);
    pulse_stop();
    pulse_stop();
    check("run_stop_stop", 16'h0000, 1'b0, 1'b0);

    key(4'd2);
    pulse_start();
    tick();
    check("dec_0001", 16'h0001, 1'b1, 1'b0);
    tick();
    check("terminal", 16'h0000, 1'b0, 1'b1);
    pulse_start();
    tick();
    check("hold1", 16'h0000, 1'b0, 1'b1);
    tick();
    check("hold2", 16'h0000, 1'b0, 1'b1);
    tick();
    check("hold_to_idle", 16'h0000, 1'b0, 1'b0);

    key(4'd1); key(4'd0);
    pulse_start();
    pulse_stop();
    check("pause", 16'h0010, 1'b0, 1'b0);
    repeat (5) tick();
    check("pause_frozen", 16'h0010, 1'b0, 1'b0);
    pulse_start();
    check("resume", 16'h0010, 1'b1, 1'b0);
    tick();
    check("resume_dec", 16'h0009, 1'b1, 1'b0);
    pulse_stop();
    check("pause2", 16'h0009, 1'b0, 1'b0);
    pulse_stop();
    check("pause_to_idle", 16'h0000, 1'b0, 1'b0);

    key(4'd5);
    pulse_start();
    bus.pgt_1Hz = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("held_high", 16'h0004, 1'b1, 1'b0);
    bus.pgt_1Hz = 1'b0;
    pulse_stop();
    pulse_stop();

    key(4'd7);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_idle", 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("start_stop_stays", 16'h0000, 1'b0, 1'b0);

    key(4'd3); key(4'd0);
    pulse_start();
    check("run_0030", 16'h0030, 1'b1, 1'b0);
    @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    expect_st("async_reset", 16'h0000, 1'b0, 1'b0);
    compare_pop();
    @(posedge clk);
    #1 clear_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset", 16'h0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
